i2s_tx: RTL

- Serializes the processed stereo sample stream from the effects pipeline into an I2S bitstream for the codec DAC.
- Generates SCLK and LRCLK from clk and holds incoming samples in a one-deep buffer.
- Loads one sample per frame and flags underrun/overrun to the control logic.
- Counterpart to the I2S receiver that feeds the pipeline input.

---
 rtl/i2s_tx.sv | 137 +++++++++++++
 1 files changed

// File: rtl/i2s_tx.sv
// I2S transmitter: divides clk down to SCLK/LRCLK and shifts out one stereo
// sample per frame, fed from a single-entry hold buffer.
module i2s_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int SCLK_HALF  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_lc_i,
    input  logic [DATA_WIDTH-1:0] data_rc_i,
    input  logic                  vld_i,
    output logic                  sclk_o,
    output logic                  lrclk_o,
    output logic                  sd_o,
    output logic                  sample_req_o,
    output logic                  underrun_o,
    output logic                  overrun_o
);

    localparam int DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int B_W   = $clog2(2 * SLOT_WIDTH);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF - 1);
    localparam logic [B_W-1:0]   B_LAST   = B_W'(2 * SLOT_WIDTH - 1);
    localparam logic [B_W-1:0]   B_SLOT   = B_W'(SLOT_WIDTH);
    localparam logic [B_W-1:0]   B_DATA   = B_W'(DATA_WIDTH);

    logic [DIV_W-1:0]      r_div;
    logic                  r_sclk;
    logic [B_W-1:0]        r_b;
    logic                  r_lrclk;
    logic                  r_sd;
    logic                  r_sampleReq;
    logic                  r_underrun;
    logic                  r_overrun;
    logic [DATA_WIDTH-1:0] r_holdL;
    logic [DATA_WIDTH-1:0] r_holdR;
    logic                  r_full;
    logic [DATA_WIDTH-1:0] r_frameL;
    logic [DATA_WIDTH-1:0] r_frameR;

    logic                  w_divTerm;
    logic                  w_fall;
    logic [B_W-1:0]        w_bNext;
    logic                  w_lrNext;
    logic [B_W-1:0]        w_pos;
    logic                  w_inData;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_sdNext;
    logic                  w_load;

    // w_pos is the bit position inside the current slot; slot position p
    // carries data bit DATA_WIDTH-p, giving the one-SCLK I2S MSB delay.
    always_comb begin
        w_divTerm = (r_div == DIV_LAST);
        w_fall    = w_divTerm & r_sclk;
        w_bNext   = (r_b == B_LAST) ? '0 : r_b + B_W'(1);
        w_lrNext  = (w_bNext >= B_SLOT);
        w_pos     = w_lrNext ? (w_bNext - B_SLOT) : w_bNext;
        w_load    = w_fall & (w_bNext == '0);
        w_inData  = (w_pos != '0) && (w_pos <= B_DATA);
        w_idx     = IDX_W'(B_DATA - w_pos);
        w_sdNext  = 1'b0;
        if (w_inData) begin
            w_sdNext = w_lrNext ? r_frameR[w_idx] : r_frameL[w_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div       <= '0;
            r_sclk      <= 1'b0;
            r_b         <= B_LAST;
            r_lrclk     <= 1'b0;
            r_sd        <= 1'b0;
            r_sampleReq <= 1'b0;
            r_underrun  <= 1'b0;
            r_overrun   <= 1'b0;
            r_holdL     <= '0;
            r_holdR     <= '0;
            r_full      <= 1'b0;
            r_frameL    <= '0;
            r_frameR    <= '0;
        end else begin
            r_sampleReq <= 1'b0;
            r_underrun  <= 1'b0;
            r_overrun   <= 1'b0;

            if (w_divTerm) begin
                r_div  <= '0;
                r_sclk <= ~r_sclk;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end

            if (w_fall) begin
                r_b     <= w_bNext;
                r_lrclk <= w_lrNext;
                r_sd    <= w_sdNext;
            end

            // Starved loads leave the frame registers alone so the last
            // sample repeats instead of dropping to silence.
            if (w_load) begin
                r_sampleReq <= 1'b1;
                if (r_full) begin
                    r_frameL <= r_holdL;
                    r_frameR <= r_holdR;
                    r_full   <= 1'b0;
                end else begin
                    r_underrun <= 1'b1;
                end
            end

            // A write in the load cycle lands after the load has taken the
            // old contents, so it is never an overrun.
            if (vld_i) begin
                r_holdL <= data_lc_i;
                r_holdR <= data_rc_i;
                r_full  <= 1'b1;
                if (r_full && !w_load) begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign sclk_o       = r_sclk;
    assign lrclk_o      = r_lrclk;
    assign sd_o         = r_sd;
    assign sample_req_o = r_sampleReq;
    assign underrun_o   = r_underrun;
    assign overrun_o    = r_overrun;

endmodule
